// File: rtl/mem_bist_pkg.sv
// Shared types and the data-pattern generator for the memory BIST engine.
package mem_bist_pkg;

  localparam int MAX_AW = 32;
  localparam int MAX_DW = 64;

  typedef enum logic [1:0] {
    MODE_CLEAR   = 2'd0,
    MODE_ADDR    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_ALL     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Result is MAX_DW wide; callers size-cast to their own DATA_WIDTH, which
  // truncates the address pattern and keeps the low checkerboard bits.
  function automatic logic [MAX_DW-1:0] pattern(input logic [MAX_AW-1:0] addr,
                                                input mode_e sel);
    logic [MAX_DW-1:0] p;
    p = '0;
    case (sel)
      MODE_ADDR: p = {{(MAX_DW-MAX_AW){1'b0}}, addr};
      MODE_CHECKER: begin
        for (int i = 0; i < MAX_DW; i++) p[i] = ~(i[0] ^ addr[0]);
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Pipelined read-data compare, saturating error counter and optional
// first-failure capture (built only when MEM_BIST_FAIL_CAPTURE_EN is defined).
module mem_bist_checker
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  cmp_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [DATA_WIDTH-1:0] act_i,
  output logic                  mismatch_o,
  output logic [ADDR_WIDTH+1:0] err_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_exp_o,
  output logic [DATA_WIDTH-1:0] fail_act_o
);

  logic                  vld_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH+1:0] err_q;

  // Memory returns data one cycle after the read strobe, so expected data
  // is delayed to line up with it.
  assign mismatch_o  = vld_q && (act_i != exp_q);
  assign err_count_o = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      vld_q <= 1'b0;
      exp_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= cmp_en_i;
      exp_q <= exp_i;
      if (mismatch_o && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

`ifdef MEM_BIST_FAIL_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_exp_q;
  logic [DATA_WIDTH-1:0] fail_act_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      addr_q      <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      addr_q <= addr_i;
      // err_q saturates rather than wrapping, so zero means no failure yet.
      if (mismatch_o && (err_q == '0)) begin
        fail_addr_q <= addr_q;
        fail_exp_q  <= exp_q;
        fail_act_q  <= act_i;
      end
    end
  end

  assign fail_addr_o = fail_addr_q;
  assign fail_exp_o  = fail_exp_q;
  assign fail_act_o  = fail_act_q;
`else
  assign fail_addr_o = '0;
  assign fail_exp_o  = '0;
  assign fail_act_o  = '0;
`endif

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: write pattern, read back, compare, report.
// Optional first-failure capture via MEM_BIST_FAIL_CAPTURE_EN.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH+1:0] err_count_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_in_o,
  input  logic [DATA_WIDTH-1:0] data_out_i,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_exp_o,
  output logic [DATA_WIDTH-1:0] fail_act_o
);

  state_e                state_q, state_d;
  mode_e                 pat_q, pat_d;
  logic                  all_q, all_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  done_q, pass_q;
  logic                  start_ok, last_addr, mismatch;
  logic [DATA_WIDTH-1:0] exp_w;

  // A start coinciding with the done pulse is dropped.
  assign start_ok  = (state_q == S_IDLE) && start_i && !done_q;
  assign last_addr = (addr_q == '1);
  assign exp_w     = DATA_WIDTH'(pattern(MAX_AW'(addr_q), pat_q));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    all_d   = all_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_WRITE;
          all_d   = (mode_i == MODE_ALL);
          pat_d   = (mode_i == MODE_ALL) ? MODE_CLEAR : mode_e'(mode_i);
          addr_d  = '0;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (last_addr) state_d = S_READ;
      end
      S_READ: begin
        addr_d = addr_q + 1'b1;
        if (last_addr) begin
          if (all_q && (pat_q != MODE_CHECKER)) begin
            state_d = S_WRITE;
            pat_d   = (pat_q == MODE_CLEAR) ? MODE_ADDR : MODE_CHECKER;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pat_q   <= MODE_CLEAR;
      all_q   <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      all_q   <= all_d;
      addr_q  <= addr_d;
      done_q  <= (state_q == S_DONE);
      // The last compare lands in the DONE cycle, so fold it in here.
      if (start_ok)                pass_q <= 1'b0;
      else if (state_q == S_DONE)  pass_q <= (err_count_o == '0) && !mismatch;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign write_o   = (state_q == S_WRITE);
  assign read_o    = (state_q == S_READ);
  assign addr_o    = addr_q;
  assign data_in_o = write_o ? exp_w : '0;

  mem_bist_checker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_checker (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (start_ok),
    .cmp_en_i   (read_o),
    .addr_i     (addr_q),
    .exp_i      (exp_w),
    .act_i      (data_out_i),
    .mismatch_o (mismatch),
    .err_count_o(err_count_o),
    .fail_addr_o(fail_addr_o),
    .fail_exp_o (fail_exp_o),
    .fail_act_o (fail_act_o)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl with a 32x8 behavioural memory.
module tb_mem_bist_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] mode;
  logic       busy, done, pass, rd, wr;
  logic [6:0] err_count;
  logic [4:0] addr, fail_addr;
  logic [7:0] data_in, data_out, fail_exp, fail_act;

  int checks = 0;
  int errors = 0;

`ifdef MEM_BIST_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_bist_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
    .read_o(rd), .write_o(wr), .addr_o(addr), .data_in_o(data_in),
    .data_out_i(data_out), .fail_addr_o(fail_addr), .fail_exp_o(fail_exp),
    .fail_act_o(fail_act)
  );

  // Behavioural memory; fault = bit 3 of address 5 stuck at 1.
  logic [7:0] mem [32];
  bit         fault = 1'b0;
  always @(posedge clk) begin
    if (wr) mem[addr] <= data_in;
    if (rd) data_out <= (fault && addr == 5'd5) ? (mem[addr] | 8'h08) : mem[addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_pat(input int a, input int ph);
    case (ph)
      1:       return 8'(a);
      2:       return (a % 2 == 1) ? 8'hAA : 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: checks strobes/data, and predicts compare outcomes via a queue.
  logic [1:0] cur_mode = 2'd0;
  int         w_cnt = 0, r_cnt = 0, pred_err = 0;
  bit         rd_pend = 1'b0;
  logic [7:0] sbq[$];

  always @(negedge clk) begin
    logic [7:0] e;
    int ph;
    if (rd_pend && sbq.size() > 0) begin
      e = sbq.pop_front();
      if (data_out !== e) pred_err++;
    end
    rd_pend = rd;
    if (busy) chk("rw_exclusive", {31'd0, rd & wr}, 32'd0);
    if (rd) begin
      ph = (cur_mode == 2'd3) ? r_cnt / 32 : int'(cur_mode);
      chk("rd_addr", {27'd0, addr}, r_cnt % 32);
      sbq.push_back(tb_pat(r_cnt % 32, ph));
      r_cnt++;
    end
    if (wr) begin
      ph = (cur_mode == 2'd3) ? w_cnt / 32 : int'(cur_mode);
      chk("wr_addr", {27'd0, addr}, w_cnt % 32);
      chk("wr_data", {24'd0, data_in}, {24'd0, tb_pat(w_cnt % 32, ph)});
      w_cnt++;
    end
  end

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_pass"}, {31'd0, pass}, 0);
    chk({tag, "_strobes"}, {30'd0, rd, wr}, 0);
    chk({tag, "_addr"}, {27'd0, addr}, 0);
    chk({tag, "_data_in"}, {24'd0, data_in}, 0);
    chk({tag, "_err"}, {25'd0, err_count}, 0);
    chk({tag, "_fail"}, {11'd0, fail_addr, fail_exp, fail_act}, 0);
  endtask

  // Returns cycle of done (start sampled at E0 = cycle 0), or -1 if aborted.
  task automatic run(input logic [1:0] m, input bit flt, input int glitch_cyc,
                     input int rst_cyc, output int dcyc);
    fault = flt; cur_mode = m; w_cnt = 0; r_cnt = 0; pred_err = 0;
    sbq.delete(); rd_pend = 1'b0;
    @(negedge clk); start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
    dcyc = 1;
    chk("busy_after_start", {31'd0, busy}, 1);
    while (!done && dcyc < 400) begin
      if (dcyc == rst_cyc) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle_zero("abort");
        dcyc = -1;
        return;
      end
      start = (dcyc == glitch_cyc);
      if (dcyc == glitch_cyc) mode = 2'd2;
      @(posedge clk); #1;
      dcyc++;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    bit         fault;
    int         done_cyc;
    int         err;
    bit         pass;
    logic [4:0] faddr;
    logic [7:0] fexp;
    logic [7:0] fact;
    int         nacc;
  } vec_t;

  vec_t vecs[4];
  int   dc, ndone;

  initial begin
    vecs[0] = '{2'd0, 1'b0,  66, 0, 1'b1, 5'd0, 8'h00, 8'h00, 32};
    vecs[1] = '{2'd1, 1'b1,  66, 1, 1'b0, 5'd5, 8'h05, 8'h0D, 32};
    vecs[2] = '{2'd2, 1'b0,  66, 0, 1'b1, 5'd0, 8'h00, 8'h00, 32};
    vecs[3] = '{2'd3, 1'b1, 194, 2, 1'b0, 5'd5, 8'h00, 8'h08, 96};

    reset = 1'b1; start = 1'b0; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run(vecs[i].mode, vecs[i].fault, -1, -1, dc);
      chk($sformatf("v%0d_done_cyc", i), dc, vecs[i].done_cyc);
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 0);
      chk($sformatf("v%0d_err", i), {25'd0, err_count}, vecs[i].err);
      chk($sformatf("v%0d_err_vs_pred", i), {25'd0, err_count}, pred_err);
      chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].pass});
      chk($sformatf("v%0d_fail_addr", i), {27'd0, fail_addr}, CAP ? {27'd0, vecs[i].faddr} : 0);
      chk($sformatf("v%0d_fail_exp", i), {24'd0, fail_exp}, CAP ? {24'd0, vecs[i].fexp} : 0);
      chk($sformatf("v%0d_fail_act", i), {24'd0, fail_act}, CAP ? {24'd0, vecs[i].fact} : 0);
      chk($sformatf("v%0d_nwr", i), w_cnt, vecs[i].nacc);
      chk($sformatf("v%0d_nrd", i), r_cnt, vecs[i].nacc);
      if (vecs[i].mode == 2'd2) begin
        chk("chk_mem6", {24'd0, mem[6]}, 32'h55);
        chk("chk_mem7", {24'd0, mem[7]}, 32'hAA);
      end
      // Start alongside done must be dropped.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("v%0d_start_on_done", i), {31'd0, busy}, 0);
      chk($sformatf("v%0d_pass_held", i), {31'd0, pass}, {31'd0, vecs[i].pass});
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 0);
    end

    // Reset at cycle 40 of a mode 1 run, then no done pulse.
    run(2'd1, 1'b0, -1, 40, dc);
    chk("abort_ret", dc, -1);
    ndone = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run(2'd1, 1'b0, -1, -1, dc);
    chk("after_abort_done_cyc", dc, 66);
    chk("after_abort_pass", {31'd0, pass}, 1);
    chk("after_abort_err", {25'd0, err_count}, 0);
    repeat (2) @(posedge clk);

    // Start with another mode while busy is ignored.
    run(2'd0, 1'b1, 10, -1, dc);
    chk("busy_start_done_cyc", dc, 66);
    chk("busy_start_err", {25'd0, err_count}, 1);
    chk("busy_start_nwr", w_cnt, 32);
    chk("busy_start_fail_act", {24'd0, fail_act}, CAP ? 32'h08 : 0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
